div_quotient_approx: RTL and testbench

Sequential Newton–Raphson quotient-approximation engine for the FPU divider. It accepts the operand significands fa and fb, iterates a reciprocal of fb on one shared registered 58×58 multiplier, and forms the quotient approximation E and the back-product Eb = E·fb. It drives the Da/Db/Eb/E/db bus consumed by the final quotient-selection stage, `select_fd`.

---
 rtl/div_quotient_approx_if.sv | 31 +++
 rtl/div_quotient_approx.sv | 166 ++++++++++++++++
 tb/tb_div_quotient_approx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/div_quotient_approx_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : div_quotient_approx_if
// Purpose  : Handshake and Da/Db/E/Eb/db result bus of the quotient engine.
// Revision : 1.0
// ============================================================================
interface div_quotient_approx_if;
    logic           start;
    logic           dbl;
    logic [52:0]    fa;
    logic [52:0]    fb;
    logic           ready;
    logic           valid;
    logic [57:0]    Da;
    logic [57:0]    Db;
    logic [54:0]    E;
    logic [114:0]   Eb;
    logic           db;

    modport master (
        output start, dbl, fa, fb,
        input  ready, valid, Da, Db, E, Eb, db
    );

    modport slave (
        input  start, dbl, fa, fb,
        output ready, valid, Da, Db, E, Eb, db
    );
endinterface
`default_nettype wire

// File: rtl/div_quotient_approx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : div_quotient_approx
// Purpose  : Newton-Raphson reciprocal iteration on one shared 58x58 multiplier
//            producing the quotient approximation E and back-product E*fb.
// Revision : 1.0
// ============================================================================
module div_quotient_approx #(
    parameter int ITER_D = 4,
    parameter int ITER_S = 3
) (
    input  wire logic               clk,
    input  wire logic               rst,
    div_quotient_approx_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MUL_T  = 3'd2,
        S_MUL_X  = 3'd3,
        S_MUL_Q  = 3'd4,
        S_MUL_QB = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [57:0]    r_x;
    logic [57:0]    r_t;
    logic [3:0]     r_cnt;
    logic [57:0]    w_mul_a;
    logic [57:0]    w_mul_b;
    logic [57:0]    w_corr;
    logic [115:0]   w_prod;
    logic [7:0]     w_x0;
    logic           w_prod_unused;

    // 2.0 is 2^58 in 1.57 and wraps to zero; t is close to 1 so 2-t stays below 2.
    assign w_corr        = 58'd0 - r_t;
    assign w_prod        = {58'd0, w_mul_a} * {58'd0, w_mul_b};
    assign w_prod_unused = w_prod[115];

    // Seed: floor(256 / (1 + (i+0.5)/16)) with i = fb[51:48].
    always_comb begin
        w_x0 = 8'd130;
        case (bus.Db[56:53])
            4'd0:  w_x0 = 8'd248;
            4'd1:  w_x0 = 8'd234;
            4'd2:  w_x0 = 8'd221;
            4'd3:  w_x0 = 8'd210;
            4'd4:  w_x0 = 8'd199;
            4'd5:  w_x0 = 8'd190;
            4'd6:  w_x0 = 8'd182;
            4'd7:  w_x0 = 8'd174;
            4'd8:  w_x0 = 8'd167;
            4'd9:  w_x0 = 8'd160;
            4'd10: w_x0 = 8'd154;
            4'd11: w_x0 = 8'd148;
            4'd12: w_x0 = 8'd143;
            4'd13: w_x0 = 8'd138;
            4'd14: w_x0 = 8'd134;
            4'd15: w_x0 = 8'd130;
            default: w_x0 = 8'd130;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        bus.ready = 1'b0;
        bus.valid = 1'b0;
        w_mul_a   = 58'd0;
        w_mul_b   = 58'd0;
        case (r_state)
            S_IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) begin
                    w_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                w_next = S_MUL_T;
            end
            S_MUL_T: begin
                w_mul_a = bus.Db;
                w_mul_b = r_x;
                w_next  = S_MUL_X;
            end
            S_MUL_X: begin
                w_mul_a = r_x;
                w_mul_b = w_corr;
                w_next  = (r_cnt == 4'd1) ? S_MUL_Q : S_MUL_T;
            end
            S_MUL_Q: begin
                w_mul_a = bus.Da;
                w_mul_b = r_x;
                w_next  = S_MUL_QB;
            end
            S_MUL_QB: begin
                w_mul_a = {3'd0, bus.E};
                w_mul_b = {5'd0, bus.Db[57:5]};
                w_next  = S_DONE;
            end
            S_DONE: begin
                bus.valid = 1'b1;
                w_next    = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.Da <= 58'd0;
            bus.Db <= 58'd0;
            bus.E  <= 55'd0;
            bus.Eb <= 115'd0;
            bus.db <= 1'b0;
            r_x    <= 58'd0;
            r_t    <= 58'd0;
            r_cnt  <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        bus.Da <= {bus.fa, 5'd0};
                        bus.Db <= {bus.fb, 5'd0};
                        bus.db <= bus.dbl;
                        r_cnt  <= bus.dbl ? 4'(ITER_D) : 4'(ITER_S);
                    end
                end
                S_LOOKUP: begin
                    r_x <= {1'b0, w_x0, 49'd0};
                end
                S_MUL_T: begin
                    r_t <= w_prod[114:57];
                end
                S_MUL_X: begin
                    r_x   <= w_prod[114:57];
                    r_cnt <= r_cnt - 4'd1;
                end
                S_MUL_Q: begin
                    bus.E <= bus.db ? w_prod[114:60] : {w_prod[114:89], 29'd0};
                end
                S_MUL_QB: begin
                    bus.Eb <= {w_prod[107:0], 7'd0};
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_quotient_approx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_div_quotient_approx
// Purpose  : Directed and random scoreboard bench for div_quotient_approx.
// Revision : 1.0
// ============================================================================
module tb_div_quotient_approx;

    localparam int LAT_D = 2 * 4 + 3;
    localparam int LAT_S = 2 * 3 + 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_quotient_approx_if bus ();

    div_quotient_approx #(
        .ITER_D (4),
        .ITER_S (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [52:0] fa;
        logic [52:0] fb;
        logic        dbl;
        int          exp_cyc;
        bit          has_win;
        logic [54:0] e_lo;
        logic [54:0] e_hi;
    } op_t;

    op_t sb[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  cyc         = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [52:0] rnd_sig();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return {1'b1, r[51:0]};
    endfunction

    task automatic check_result();
        op_t          e;
        logic [127:0] prod;
        logic [127:0] num;
        logic [127:0] diff;
        e    = sb.pop_front();
        prod = 128'(bus.E) * 128'(e.fb);
        num  = 128'(e.fa) << 54;
        diff = (num > prod) ? (num - prod) : (prod - num);
        chk("valid_cycle", 128'(cyc), 128'(e.exp_cyc));
        chk("Da", 128'(bus.Da), 128'({e.fa, 5'd0}));
        chk("Db", 128'(bus.Db), 128'({e.fb, 5'd0}));
        chk("db", 128'(bus.db), 128'(e.dbl));
        chk("Eb_exact", 128'(bus.Eb), 128'({prod[107:0], 7'd0}));
        if (e.dbl) begin
            chk("acc_double", 128'(diff < (128'(e.fb) << 1)), 128'(1));
        end else begin
            chk("acc_single", 128'(diff <= (128'(e.fb) << 29)), 128'(1));
            chk("E_low_zero", 128'(bus.E[28:0]), 128'(0));
        end
        if (e.has_win) begin
            chk("E_window", 128'((bus.E >= e.e_lo) && (bus.E <= e.e_hi)), 128'(1));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.valid === 1'b1) begin
            chk("valid_expected", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) begin
                check_result();
            end
        end
    endtask

    task automatic issue(input logic [52:0] fa, input logic [52:0] fb, input logic dbl,
                         input bit has_win, input logic [54:0] lo, input logic [54:0] hi);
        op_t e;
        chk("ready_at_start", 128'(bus.ready), 128'(1));
        bus.fa    = fa;
        bus.fb    = fb;
        bus.dbl   = dbl;
        bus.start = 1'b1;
        e.fa      = fa;
        e.fb      = fb;
        e.dbl     = dbl;
        e.exp_cyc = cyc + 1 + (dbl ? LAT_D : LAT_S);
        e.has_win = has_win;
        e.e_lo    = lo;
        e.e_hi    = hi;
        sb.push_back(e);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("valid_timeout", 128'(sb.size()), 128'(0));
        sb.delete();
    endtask

    task automatic wait_done(input int budget);
        wait_valid(budget);
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.dbl   = 1'b0;
        bus.fa    = 53'd0;
        bus.fb    = 53'd0;

        tick();
        chk("rst_ready", 128'(bus.ready), 128'(1));
        chk("rst_valid", 128'(bus.valid), 128'(0));
        chk("rst_E", 128'(bus.E), 128'(0));
        chk("rst_Eb", 128'(bus.Eb), 128'(0));
        chk("rst_Da", 128'(bus.Da), 128'(0));
        rst = 1'b0;
        tick();

        // Identity: 1/1 converges to 1 - 2^-54 or exactly 1
        issue(53'h10000000000000, 53'h10000000000000, 1'b1, 1'b1,
              55'h3FFFFFFFFFFFFF, 55'h40000000000000);
        wait_done(30);

        // Abort a double op while it sits in MUL_X
        issue(53'h18000000000000, 53'h14000000000000, 1'b1, 1'b0, 55'd0, 55'd0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("abort_ready", 128'(bus.ready), 128'(1));
        chk("abort_valid", 128'(bus.valid), 128'(0));
        chk("abort_Da", 128'(bus.Da), 128'(0));
        chk("abort_Db", 128'(bus.Db), 128'(0));
        chk("abort_E", 128'(bus.E), 128'(0));
        chk("abort_Eb", 128'(bus.Eb), 128'(0));
        chk("abort_db", 128'(bus.db), 128'(0));
        sb.delete();
        tick();
        rst = 1'b0;
        repeat (15) tick();

        // Two-thirds within one ulp
        issue(53'h10000000000000, 53'h18000000000000, 1'b1, 1'b1,
              55'h2AAAAAAAAAAAA9, 55'h2AAAAAAAAAAAAB);
        wait_done(30);

        // Single precision 1.5 / 1.0
        issue(53'h18000000000000, 53'h10000000000000, 1'b0, 1'b1,
              55'h5FFFFFE0000000, 55'h60000020000000);
        wait_done(30);

        // Handshake: starts during busy and during DONE are ignored
        issue(53'h18000000000000, 53'h10000000000000, 1'b1, 1'b1,
              55'h5FFFFFFFFFFFFF, 55'h60000000000000);
        repeat (3) tick();
        bus.fa    = 53'h10000000000000;
        bus.fb    = 53'h10000000000000;
        bus.start = 1'b1;
        chk("busy_ready", 128'(bus.ready), 128'(0));
        tick();
        bus.start = 1'b0;
        wait_valid(30);
        bus.fa    = 53'h10000000000000;
        bus.fb    = 53'h10000000000000;
        bus.start = 1'b1;
        chk("done_ready", 128'(bus.ready), 128'(0));
        tick();
        issue(rnd_sig(), 53'h1C000000000000, 1'b1, 1'b0, 55'd0, 55'd0);
        wait_done(30);

        // Every lookup index with the largest fb in its interval
        for (int i = 0; i < 16; i++) begin
            issue(rnd_sig(), {1'b1, 4'(i), 48'hFFFFFFFFFFFF}, 1'b1, 1'b0, 55'd0, 55'd0);
            wait_done(30);
        end

        for (int k = 0; k < 200; k++) begin
            issue(rnd_sig(), rnd_sig(), 1'b1, 1'b0, 55'd0, 55'd0);
            wait_done(30);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
